// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    BUF  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] PC_STEP              = 32'd4;

  // Instructions are word aligned, so redirect targets lose their low two bits.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_fetch_buffer.sv
// One-entry holding register: a fetched word parked while decode stalls,
// plus a redirect target that arrived while a memory access was outstanding.
module fetch_buffer
  import fetch_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_load,
  input  logic [31:0] instr_in,
  input  logic        pend_set,
  input  logic        pend_clear,
  input  logic [31:0] pend_target_in,
  output logic [31:0] buf_instr,
  output logic        pend_valid,
  output logic [31:0] pend_target
);

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_instr   <= '0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      if (instr_load) begin
        buf_instr <= instr_in;
      end
      // A newer redirect always replaces an older pending one.
      if (pend_set) begin
        pend_valid  <= 1'b1;
        pend_target <= pend_target_in;
      end else if (pend_clear) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC register load interface, issues instruction
// fetches and fills the IF/ID register, arbitrating sequential flow, redirects and stalls.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] NOP_INSTR    = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic [31:0] next_pc,
  output logic        hold_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc
);

  fetch_state_t state;
  fetch_state_t state_next;

  logic        ifid_load;
  logic        ifid_from_buf;
  logic        ifid_flush;
  logic        buf_load;
  logic        pend_set;
  logic        pend_clear;
  logic [31:0] buf_instr;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic [31:0] target_aligned;

  assign target_aligned = align_pc(redirect_target);
  assign imem_addr      = pc_in;

  fetch_buffer u_fetch_buffer (
    .clk            (clk),
    .reset          (reset),
    .instr_load     (buf_load),
    .instr_in       (imem_rdata),
    .pend_set       (pend_set),
    .pend_clear     (pend_clear),
    .pend_target_in (target_aligned),
    .buf_instr      (buf_instr),
    .pend_valid     (pend_valid),
    .pend_target    (pend_target)
  );

  // Request arbitration; the PC register is held by default so the fetch
  // address stays stable while a request is outstanding.
  always_comb begin
    state_next    = state;
    imem_req      = 1'b0;
    hold_pc       = 1'b1;
    next_pc       = pc_in;
    ifid_load     = 1'b0;
    ifid_from_buf = 1'b0;
    ifid_flush    = 1'b0;
    buf_load      = 1'b0;
    pend_set      = 1'b0;
    pend_clear    = 1'b0;
    case (state)
      BOOT: begin
        hold_pc    = 1'b0;
        next_pc    = RESET_VECTOR;
        state_next = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (redirect && imem_ack) begin
          next_pc    = target_aligned;
          hold_pc    = 1'b0;
          ifid_flush = 1'b1;
          pend_clear = 1'b1;
        end else if (redirect) begin
          pend_set   = 1'b1;
          ifid_flush = 1'b1;
        end else if (imem_ack && pend_valid) begin
          // The returning word belongs to the abandoned path.
          next_pc    = pend_target;
          hold_pc    = 1'b0;
          pend_clear = 1'b1;
          ifid_flush = 1'b1;
        end else if (imem_ack && !stall) begin
          ifid_load = 1'b1;
          next_pc   = pc_in + PC_STEP;
          hold_pc   = 1'b0;
        end else if (imem_ack) begin
          buf_load   = 1'b1;
          state_next = BUF;
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
      end
      BUF: begin
        if (redirect) begin
          next_pc    = target_aligned;
          hold_pc    = 1'b0;
          ifid_flush = 1'b1;
          state_next = REQ;
        end else if (!stall) begin
          ifid_load     = 1'b1;
          ifid_from_buf = 1'b1;
          next_pc       = pc_in + PC_STEP;
          hold_pc       = 1'b0;
          state_next    = REQ;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT;
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
      ifid_pc    <= '0;
    end else begin
      state <= state_next;
      if (ifid_load) begin
        ifid_valid <= 1'b1;
        ifid_instr <= ifid_from_buf ? buf_instr : imem_rdata;
        ifid_pc    <= pc_in;
      end else if (ifid_flush) begin
        ifid_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer with a hold-when-high PC register
// and an address-derived instruction memory.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] pc_reg;
  logic [31:0] next_pc;
  logic        hold_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;

  int checks = 0;
  int errors = 0;

  fetch_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .pc_in           (pc_reg),
    .next_pc         (next_pc),
    .hold_pc         (hold_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .ifid_valid      (ifid_valid),
    .ifid_instr      (ifid_instr),
    .ifid_pc         (ifid_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External PC register with hold-when-high semantics.
  initial pc_reg = 32'h0000_0000;
  always @(posedge clk) begin
    if (hold_pc === 1'b0) pc_reg <= next_pc;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // Set this cycle's inputs, then move to the falling edge to sample outputs.
  task automatic drive(input logic a, input logic s, input logic r, input logic [31:0] t);
    imem_ack = a;
    stall = s;
    redirect = r;
    redirect_target = t;
    @(negedge clk);
  endtask

  task automatic clock_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_ack = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = '0;
    clock_edge();
    clock_edge();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || hold_pc !== 1'b0 || next_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_comb: req=%b hold=%b next_pc=%h, required 0 0 00000000", imem_req, hold_pc, next_pc);
    end
    checks++;
    if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_ifid: valid=%b instr=%h pc=%h, required 0 00000000 00000000", ifid_valid, ifid_instr, ifid_pc);
    end
    clock_edge();
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    do_reset();
    drive(0, 0, 0, 0);
    checks++;
    if (next_pc !== 32'h0 || hold_pc !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL boot_cycle: next_pc=%h hold=%b req=%b, required 00000000 0 0", next_pc, hold_pc, imem_req);
    end
    clock_edge();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i) || next_pc !== 32'(4 * i + 4) || hold_pc !== 1'b0) begin
        errors++;
        $display("[TB] FAIL seq_req%0d: req=%b addr=%h next_pc=%h hold=%b, required 1 %h %h 0",
                 i, imem_req, imem_addr, next_pc, hold_pc, 32'(4 * i), 32'(4 * i + 4));
      end
      clock_edge();
      checks++;
      if (ifid_valid !== 1'b1 || ifid_pc !== 32'(4 * i) || ifid_instr !== mem_word(32'(4 * i))) begin
        errors++;
        $display("[TB] FAIL seq_ifid%0d: valid=%b pc=%h instr=%h, required 1 %h %h",
                 i, ifid_valid, ifid_pc, ifid_instr, 32'(4 * i), mem_word(32'(4 * i)));
      end
    end
  endtask

  task automatic test_delayed_ack();
    do_reset();
    drive(0, 0, 0, 0); clock_edge();
    drive(1, 0, 0, 0); clock_edge();
    drive(1, 0, 0, 0); clock_edge();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      checks++;
      if (hold_pc !== 1'b1 || imem_addr !== 32'h8) begin
        errors++;
        $display("[TB] FAIL wait_hold%0d: hold=%b addr=%h, required 1 00000008", i, hold_pc, imem_addr);
      end
      clock_edge();
      checks++;
      if (ifid_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wait_bubble%0d: ifid_valid=%b, required 0", i, ifid_valid);
      end
    end
    drive(1, 0, 0, 0);
    checks++;
    if (next_pc !== 32'hC || hold_pc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL late_ack_next: next_pc=%h hold=%b, required 0000000c 0", next_pc, hold_pc);
    end
    clock_edge();
    checks++;
    if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8 || ifid_instr !== mem_word(32'h8)) begin
      errors++;
      $display("[TB] FAIL late_ack_ifid: valid=%b pc=%h instr=%h, required 1 00000008 %h",
               ifid_valid, ifid_pc, ifid_instr, mem_word(32'h8));
    end
  endtask

  task automatic test_stall_buffer();
    do_reset();
    drive(0, 0, 0, 0); clock_edge();
    drive(1, 0, 0, 0); clock_edge();
    drive(1, 1, 0, 0);
    checks++;
    if (hold_pc !== 1'b1 || imem_addr !== 32'h4) begin
      errors++;
      $display("[TB] FAIL stall_ack_hold: hold=%b addr=%h, required 1 00000004", hold_pc, imem_addr);
    end
    clock_edge();
    checks++;
    if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL stall_ifid_held: valid=%b pc=%h, required 1 00000000", ifid_valid, ifid_pc);
    end
    drive(0, 1, 0, 0);
    checks++;
    if (imem_req !== 1'b0 || hold_pc !== 1'b1) begin
      errors++;
      $display("[TB] FAIL buf_stalled: req=%b hold=%b, required 0 1", imem_req, hold_pc);
    end
    clock_edge();
    drive(0, 0, 0, 0);
    checks++;
    if (next_pc !== 32'h8 || hold_pc !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL buf_release: next_pc=%h hold=%b req=%b, required 00000008 0 0", next_pc, hold_pc, imem_req);
    end
    clock_edge();
    checks++;
    if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4 || ifid_instr !== mem_word(32'h4)) begin
      errors++;
      $display("[TB] FAIL buf_ifid: valid=%b pc=%h instr=%h, required 1 00000004 %h",
               ifid_valid, ifid_pc, ifid_instr, mem_word(32'h4));
    end
    drive(1, 0, 0, 0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      errors++;
      $display("[TB] FAIL buf_resume: req=%b addr=%h, required 1 00000008", imem_req, imem_addr);
    end
    clock_edge();
  endtask

  task automatic test_redirect_pending();
    do_reset();
    drive(0, 0, 0, 0); clock_edge();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0); clock_edge();
    end
    drive(0, 0, 1, 32'h40);
    checks++;
    if (hold_pc !== 1'b1 || imem_addr !== 32'h10) begin
      errors++;
      $display("[TB] FAIL redir_pend_hold: hold=%b addr=%h, required 1 00000010", hold_pc, imem_addr);
    end
    clock_edge();
    checks++;
    if (ifid_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redir_pend_flush: ifid_valid=%b, required 0", ifid_valid);
    end
    drive(0, 0, 0, 0); clock_edge();
    drive(1, 0, 0, 0);
    checks++;
    if (next_pc !== 32'h40 || hold_pc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redir_pend_next: next_pc=%h hold=%b, required 00000040 0", next_pc, hold_pc);
    end
    clock_edge();
    checks++;
    if (ifid_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redir_pend_drop: ifid_valid=%b, required 0", ifid_valid);
    end
    drive(1, 0, 0, 0);
    checks++;
    if (imem_addr !== 32'h40 || next_pc !== 32'h44) begin
      errors++;
      $display("[TB] FAIL redir_target_req: addr=%h next_pc=%h, required 00000040 00000044", imem_addr, next_pc);
    end
    clock_edge();
    checks++;
    if (ifid_valid !== 1'b1 || ifid_pc !== 32'h40) begin
      errors++;
      $display("[TB] FAIL redir_target_ifid: valid=%b pc=%h, required 1 00000040", ifid_valid, ifid_pc);
    end
    drive(1, 0, 1, 32'h80);
    checks++;
    if (next_pc !== 32'h80 || hold_pc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redir_with_ack: next_pc=%h hold=%b, required 00000080 0", next_pc, hold_pc);
    end
    clock_edge();
    checks++;
    if (ifid_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redir_with_ack_flush: ifid_valid=%b, required 0", ifid_valid);
    end
  endtask

  task automatic test_buf_redirect();
    do_reset();
    drive(0, 0, 0, 0); clock_edge();
    drive(1, 0, 0, 0); clock_edge();
    drive(1, 1, 0, 0); clock_edge();
    drive(0, 1, 1, 32'h103);
    checks++;
    if (next_pc !== 32'h100 || hold_pc !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL buf_redir_next: next_pc=%h hold=%b req=%b, required 00000100 0 0", next_pc, hold_pc, imem_req);
    end
    clock_edge();
    checks++;
    if (ifid_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL buf_redir_flush: ifid_valid=%b, required 0", ifid_valid);
    end
    drive(1, 0, 0, 0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || next_pc !== 32'h104) begin
      errors++;
      $display("[TB] FAIL buf_redir_req: req=%b addr=%h next_pc=%h, required 1 00000100 00000104", imem_req, imem_addr, next_pc);
    end
    clock_edge();
    checks++;
    if (ifid_valid !== 1'b1 || ifid_pc !== 32'h100 || ifid_instr !== mem_word(32'h100)) begin
      errors++;
      $display("[TB] FAIL buf_redir_ifid: valid=%b pc=%h instr=%h, required 1 00000100 %h",
               ifid_valid, ifid_pc, ifid_instr, mem_word(32'h100));
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    drive(0, 0, 0, 0); clock_edge();
    drive(0, 0, 1, 32'hFFFF_FFFC); clock_edge();
    drive(1, 0, 0, 0);
    checks++;
    if (next_pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("[TB] FAIL wrap_jump: next_pc=%h, required fffffffc", next_pc);
    end
    clock_edge();
    drive(1, 0, 0, 0);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC || next_pc !== 32'h0 || hold_pc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_next: addr=%h next_pc=%h hold=%b, required fffffffc 00000000 0", imem_addr, next_pc, hold_pc);
    end
    clock_edge();
    checks++;
    if (ifid_valid !== 1'b1 || ifid_pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("[TB] FAIL wrap_ifid: valid=%b pc=%h, required 1 fffffffc", ifid_valid, ifid_pc);
    end
    drive(1, 0, 0, 0); clock_edge();
    reset = 1'b1;
    drive(0, 0, 0, 0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      errors++;
      $display("[TB] FAIL midreq_active: req=%b addr=%h, required 1 00000004", imem_req, imem_addr);
    end
    clock_edge();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || ifid_valid !== 1'b0 || next_pc !== 32'h0 || hold_pc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreq_dropped: req=%b valid=%b next_pc=%h hold=%b, required 0 0 00000000 0",
               imem_req, ifid_valid, next_pc, hold_pc);
    end
    clock_edge();
    drive(1, 0, 0, 0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL restart_req: req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
    end
    clock_edge();
    checks++;
    if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL restart_ifid: valid=%b pc=%h, required 1 00000000", ifid_valid, ifid_pc);
    end
  endtask

  initial begin
    reset = 1'b1;
    imem_ack = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = '0;
    test_reset();
    test_sequential();
    test_delayed_ack();
    test_stall_buffer();
    test_redirect_pending();
    test_buf_redirect();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
